rx_fifo_ctrl: RTL and testbench

//  Receive-side buffer between the UART receive engine and the TramelBlaze port bus.
//  - Captures each completed frame (8-bit data plus parity/framing flags) into a FIFO.
//  - Returns the one-cycle reads0 pulse that clears the engine's RxRdy/perr/ferr/ovf.
//  - Gives the CPU a data-read port and a status-read port.
//  - Optional interrupt to the CPU.

---
 rtl/rx_fifo_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_rx_fifo_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_fifo_ctrl.sv
// Receive-side frame FIFO between the UART receive engine and the CPU port bus.
// Optional interrupt output is built when RX_FIFO_IRQ_EN is defined.
module rx_fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_rdy,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_perr,
  input  logic       i_rx_ferr,
  input  logic       i_rx_ovf,
  output logic       o_reads0,
  input  logic       i_cpu_rd,
  input  logic       i_cpu_rd_stat,
  output logic [7:0] o_dout,
  output logic [7:0] o_status,
  output logic       o_irq,
  input  logic       i_irq_ack
);

  localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAPT = 2'd1,
    S_CLR  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [9:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic [AW:0]     w_count_next;
  logic [7:0]      r_dout;
  logic            r_last_perr;
  logic            r_last_ferr;
  logic            r_fifo_ovf;
  logic            r_eng_ovf;

  logic            w_full;
  logic            w_nempty;
  logic            w_push;
  logic            w_pop;
  logic            w_fovf_set;
  logic            w_eovf_set;
  logic [9:0]      w_head;

  // Capture sequencer: one write attempt per RxRdy assertion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_reads0     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_rx_rdy) begin
          w_state_next = S_CAPT;
        end
      end
      S_CAPT: begin
        w_state_next = S_CLR;
      end
      S_CLR: begin
        o_reads0     = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (!i_rx_rdy) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_full     = (r_count == C_DEPTH);
  assign w_nempty   = (r_count != '0);
  assign w_push     = (r_state == S_CAPT) && !w_full;
  assign w_pop      = i_cpu_rd && w_nempty;
  assign w_fovf_set = (r_state == S_CAPT) && w_full;
  assign w_eovf_set = (r_state == S_CAPT) && i_rx_ovf;
  assign w_head     = r_mem[r_rptr];

  // Storage array carries no reset so it maps onto distributed/block RAM.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {i_rx_perr, i_rx_ferr, i_rx_data};
    end
  end

  always_comb begin
    w_count_next = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + C_CNT_ONE;
      2'b01:   w_count_next = r_count - C_CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + C_PTR_ONE;
      end
      r_count <= w_count_next;
    end
  end

  // Popped data and its flags; a pop on an empty FIFO leaves all of them alone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dout      <= 8'h00;
      r_last_perr <= 1'b0;
      r_last_ferr <= 1'b0;
    end else if (w_pop) begin
      r_dout      <= w_head[7:0];
      r_last_perr <= w_head[9];
      r_last_ferr <= w_head[8];
    end
  end

  // Sticky overflow bits: a set in the status-read cycle beats the clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fifo_ovf <= 1'b0;
      r_eng_ovf  <= 1'b0;
    end else begin
      r_fifo_ovf <= w_fovf_set | (r_fifo_ovf & ~i_cpu_rd_stat);
      r_eng_ovf  <= w_eovf_set | (r_eng_ovf & ~i_cpu_rd_stat);
    end
  end

  assign o_dout   = r_dout;
  assign o_status = {2'b00, r_fifo_ovf, r_eng_ovf, r_last_ferr, r_last_perr, w_full, w_nempty};

`ifdef RX_FIFO_IRQ_EN
  logic r_irq;
  logic w_irq_set;

  // Pops are impossible when empty, so a push from count 0 is exactly the 0->1 step.
  assign w_irq_set = (!w_nempty && w_push)
                   | (w_fovf_set && !r_fifo_ovf)
                   | (w_eovf_set && !r_eng_ovf);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq <= 1'b0;
    end else if (i_irq_ack) begin
      r_irq <= 1'b0;
    end else if (w_irq_set) begin
      r_irq <= 1'b1;
    end
  end

  assign o_irq = r_irq;
`else
  logic w_unused_irq_ack;

  assign w_unused_irq_ack = i_irq_ack;
  assign o_irq            = 1'b0;
`endif

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Self-checking bench for rx_fifo_ctrl: vector table, directed corner sequences,
// then random traffic against a queue-based reference model.
module tb_rx_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef RX_FIFO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_perr = 1'b0;
  logic       rx_ferr = 1'b0;
  logic       rx_ovf = 1'b0;
  logic       reads0;
  logic       cpu_rd = 1'b0;
  logic       cpu_rd_stat = 1'b0;
  logic [7:0] dout;
  logic [7:0] status;
  logic       irq;
  logic       irq_ack = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rx_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx_rdy     (rx_rdy),
    .i_rx_data    (rx_data),
    .i_rx_perr    (rx_perr),
    .i_rx_ferr    (rx_ferr),
    .i_rx_ovf     (rx_ovf),
    .o_reads0     (reads0),
    .i_cpu_rd     (cpu_rd),
    .i_cpu_rd_stat(cpu_rd_stat),
    .o_dout       (dout),
    .o_status     (status),
    .o_irq        (irq),
    .i_irq_ack    (irq_ack)
  );

  // Reference model: frame handshake phase, FIFO contents as a queue, sticky flags.
  logic [9:0] m_q[$];
  int         m_phase;
  logic [7:0] m_dout;
  bit         m_lp, m_lf, m_fovf, m_eovf, m_irq;

  function automatic void model_reset();
    m_q.delete();
    m_phase = 0;
    m_dout  = 8'h00;
    m_lp = 0; m_lf = 0; m_fovf = 0; m_eovf = 0; m_irq = 0;
  endfunction

  function automatic logic [7:0] model_status();
    return {2'b00, m_fovf, m_eovf, m_lf, m_lp, m_q.size() == DEPTH, m_q.size() != 0};
  endfunction

  function automatic void model_step(bit rr, logic [7:0] d, bit p, bit f, bit o,
                                     bit rd, bit rs, bit ack);
    int  sz0;
    bit  attempt, fset, eset, irq_set;
    sz0     = m_q.size();
    attempt = (m_phase == 1);
    fset    = attempt && (sz0 == DEPTH);
    eset    = attempt && o;
    if (rd && sz0 != 0) begin
      logic [9:0] e;
      e      = m_q.pop_front();
      m_dout = e[7:0];
      m_lp   = e[9];
      m_lf   = e[8];
    end
    if (attempt && sz0 != DEPTH) m_q.push_back({p, f, d});
    irq_set = (sz0 == 0 && m_q.size() == 1) || (fset && !m_fovf) || (eset && !m_eovf);
    if (IRQ_ON) begin
      if (ack) m_irq = 0;
      else if (irq_set) m_irq = 1;
    end
    m_fovf = fset || (m_fovf && !rs);
    m_eovf = eset || (m_eovf && !rs);
    case (m_phase)
      0: if (rr) m_phase = 1;
      1: m_phase = 2;
      2: m_phase = 3;
      default: if (!rr) m_phase = 0;
    endcase
  endfunction

  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %02h, expected %02h", name, $time, act, exp);
    end
  endfunction

  function automatic void compare_model();
    chk("reads0", {7'b0, reads0}, {7'b0, m_phase == 2});
    chk("dout",   dout,           m_dout);
    chk("status", status,         model_status());
    chk("irq",    {7'b0, irq},    {7'b0, m_irq});
  endfunction

  // Called at a falling edge: drive one cycle of inputs, advance model, check after the edge.
  task automatic tick(input bit rr, input logic [7:0] d, input bit p, input bit f, input bit o,
                      input bit rd, input bit rs, input bit ack);
    rx_rdy = rr; rx_data = d; rx_perr = p; rx_ferr = f; rx_ovf = o;
    cpu_rd = rd; cpu_rd_stat = rs; irq_ack = ack;
    model_step(rr, d, p, f, o, rd, rs, ack);
    @(negedge clk);
    compare_model();
  endtask

  task automatic send_frame(input logic [7:0] d, input bit p, input bit f, input bit o,
                            input bit rd_capt, input bit rs_capt);
    tick(1, d, p, f, o, 0, 0, 0);
    tick(1, d, p, f, o, rd_capt, rs_capt, 0);
    tick(1, d, p, f, o, 0, 0, 0);
    tick(0, d, p, f, o, 0, 0, 0);
  endtask

  task automatic pop();
    tick(0, 8'h00, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_status", status, 8'h00);
    chk("rst_reads0", {7'b0, reads0}, 8'h00);
    chk("rst_dout",   dout, 8'h00);
    chk("rst_irq",    {7'b0, irq}, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         rr;
    logic [7:0] d;
    bit         p, f, o, rd, rs;
    bit         exp_r0;
    logic [7:0] exp_dout;
    logic [7:0] exp_stat;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Single A5 frame then pop; then 3C frame with all error flags, pop, status read, empty pop.
    tbl[0]  = '{1, 8'hA5, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00};
    tbl[1]  = '{1, 8'hA5, 0, 0, 0, 0, 0, 1, 8'h00, 8'h01};
    tbl[2]  = '{1, 8'hA5, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01};
    tbl[3]  = '{0, 8'hA5, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01};
    tbl[4]  = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 8'hA5, 8'h00};
    tbl[5]  = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h00};
    tbl[6]  = '{1, 8'h3C, 1, 1, 1, 0, 0, 0, 8'hA5, 8'h00};
    tbl[7]  = '{1, 8'h3C, 1, 1, 1, 0, 0, 1, 8'hA5, 8'h11};
    tbl[8]  = '{0, 8'h3C, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h11};
    tbl[9]  = '{0, 8'h3C, 0, 0, 0, 1, 0, 0, 8'h3C, 8'h1C};
    tbl[10] = '{0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h3C, 8'h0C};
    tbl[11] = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h3C, 8'h0C};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].rr, tbl[i].d, tbl[i].p, tbl[i].f, tbl[i].o, tbl[i].rd, tbl[i].rs, 1'b0);
      chk($sformatf("tbl%0d_reads0", i), {7'b0, reads0}, {7'b0, tbl[i].exp_r0});
      chk($sformatf("tbl%0d_dout", i),   dout,   tbl[i].exp_dout);
      chk($sformatf("tbl%0d_status", i), status, tbl[i].exp_stat);
    end

    // Reset while a frame is in capture with three entries stored; frame still pending after.
    do_reset();
    for (int i = 0; i < 4; i++) send_frame(8'h40 + 8'(i), 0, 0, 0, 0, 0);
    pop();
    chk("pre_rst_dout", dout, 8'h40);
    tick(1, 8'h77, 0, 0, 0, 0, 0, 0);
    do_reset();
    tick(1, 8'h77, 0, 0, 0, 0, 0, 0);
    tick(1, 8'h77, 0, 0, 0, 0, 0, 0);
    chk("post_rst_reads0", {7'b0, reads0}, 8'h01);
    tick(0, 8'h77, 0, 0, 0, 0, 0, 0);
    tick(0, 8'h77, 0, 0, 0, 0, 0, 0);
    chk("post_rst_status", status, 8'h01);
    pop();
    chk("post_rst_dout", dout, 8'h77);

    // Fill past depth.
    do_reset();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0, 0, 0);
    chk("fill_status", status, 8'h23);
    for (int i = 1; i <= 8; i++) begin
      pop();
      chk($sformatf("fill_pop%0d", i), dout, 8'(i));
    end
    chk("drain_status", status, 8'h20);
    tick(0, 8'h00, 0, 0, 0, 0, 1, 0);
    chk("stat_clear", status, 8'h00);

    // Push and pop in the same cycle, at DEPTH-1 and at full.
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) send_frame(8'h10 + 8'(i), 0, 0, 0, 0, 0);
    send_frame(8'h20, 0, 0, 0, 1, 0);
    chk("conc_status", status, 8'h01);
    chk("conc_dout", dout, 8'h10);
    send_frame(8'h21, 0, 0, 0, 0, 0);
    chk("conc_full", status, 8'h03);
    send_frame(8'h22, 0, 0, 0, 1, 0);
    chk("full_pop_status", status, 8'h21);
    send_frame(8'h23, 0, 0, 0, 0, 0);
    send_frame(8'h24, 0, 0, 0, 0, 1);
    chk("set_wins_status", status, 8'h23);
    do_reset();
    send_frame(8'h5A, 0, 0, 0, 0, 0);
    pop();
    pop();
    chk("empty_pop_dout", dout, 8'h5A);

    // Interrupt: first frame raises, ack clears, non-empty frame leaves it low.
    do_reset();
    tick(1, 8'h66, 0, 0, 0, 0, 0, 0);
    tick(1, 8'h66, 0, 0, 0, 0, 0, 0);
    chk("irq_first", {7'b0, irq}, {7'b0, IRQ_ON});
    tick(1, 8'h66, 0, 0, 0, 0, 0, 0);
    tick(0, 8'h66, 0, 0, 0, 0, 0, 1);
    chk("irq_ack", {7'b0, irq}, 8'h00);
    send_frame(8'h67, 0, 0, 0, 0, 0);
    chk("irq_second", {7'b0, irq}, 8'h00);

    // Random traffic against the model.
    do_reset();
    begin
      bit rr = 0;
      for (int c = 0; c < 2000; c++) begin
        if ($urandom_range(0, 3) == 0) rr = ~rr;
        tick(rr, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
